frame_update_controller: RTL and testbench
==========================================

FRAME_UPDATE_CONTROLLER -- requirements
Module: frame_update_controller

Interface
REQ-001 Parameter DWELL_FRAMES, default 120: frames each display page is shown before rotating.
REQ-002 Parameter BLINK_FRAMES, default 30: frames per half-period of oblink.
REQ-003 iclock  in  1  pixel clock, shared with the sync generators.
REQ-004 ireset_n  in  1  asynchronous, active-low reset.
REQ-005 ivsync  in  1  vertical sync from the vertical sync generator, active-low pulse.
REQ-006 itemperatura  in  4  live temperature code.
REQ-007 idig_temp  in  4  live temperature digit select, bits [4:1].
REQ-008 iautor  in  16  author field offered by the player.
REQ-009 imusica  in  16  song field offered by the player.
REQ-010 imusica_atual  in  1  current-song index offered by the player.
REQ-011 iupd_req  in  1  player request to commit the song fields; held high until oupd_ack is seen.
REQ-012 otemperatura  out  4  frame-stable temperature for the pixel generator.
REQ-013 odig_temp  out  4  frame-stable digit select.
REQ-014 oautor  out  16  frame-stable author.
REQ-015 omusica  out  16  frame-stable song.
REQ-016 omusica_atual  out  1  frame-stable song index.
REQ-017 oupd_ack  out  1  commit acknowledge.
REQ-018 opage  out  2  page select: 0 = temperature, 1 = song, 2 = author.
REQ-019 oblink  out  1  cursor blink.
REQ-020 oframe_tick  out  1  one-cycle pulse at each frame boundary.

Function
REQ-021 Frame boundary
- ivsync is registered twice.
- A 1->0 transition of the registered value produces oframe_tick, high for exactly one iclock cycle.
- Latency: 2 cycles from the ivsync edge.
REQ-022 Temperature shadows: otemperatura and odig_temp load from their inputs on every frame tick, and only on a frame tick.
REQ-023 Song shadows: oautor, omusica and omusica_atual load only on the COMMIT action of the state machine (REQ-024).
REQ-024 State machine
- RUN: if iupd_req is high, go to WAIT.
  - If a frame tick occurs in the same cycle, COMMIT immediately and go to ACK.
- WAIT: on a frame tick, COMMIT and go to ACK.
  - If iupd_req drops before the tick, return to RUN with no commit.
- ACK: oupd_ack is high; when iupd_req is low, drop oupd_ack and go to RUN.
REQ-025 oupd_ack is registered.
- It rises the cycle after COMMIT and is high only in ACK.
- The earliest new request is accepted the cycle after ACK exits.
REQ-026 Page rotation
- A frame counter increments on each tick.
- On reaching DWELL_FRAMES-1 with a tick, it wraps to 0 and opage advances 0->1->2->0.
- opage never holds 3; if 3 is ever reached, the next tick forces 0.
REQ-027 Song change: when COMMIT changes omusica_atual, opage is forced to 1 and the frame counter cleared in the same cycle, overriding a coincident rotation.
REQ-028 Blink: a separate counter toggles oblink on every BLINK_FRAMES-th tick and wraps to 0 at that point.
REQ-029 Counter widths: each counter is clog2 of its parameter, minimum 1 bit, with no overflow beyond its wrap value.
REQ-030 Outputs change only at frame ticks or COMMIT, never in the middle of a frame otherwise.

Reset
REQ-031 With ireset_n low, all of the following are 0 asynchronously:
- outputs: otemperatura, odig_temp, oautor, omusica, omusica_atual, oupd_ack, opage, oblink, oframe_tick;
- internals: counters and the ivsync synchronizer (reset to 1).
- The state is RUN.
REQ-032 Reset asserted in WAIT or ACK discards the request.
- After release the player must present iupd_req anew; a still-high iupd_req is treated as a new request.
REQ-033 No frame tick is generated by the first sampled ivsync value after reset release.

Structure
REQ-034 A shared package holds:
- the state encodings RUN/WAIT/ACK;
- the page encodings PAGE_TEMP = 0, PAGE_SONG = 1, PAGE_AUTHOR = 2.
REQ-035 One sub-module, vsync_edge_detect, contains the synchronizer and the falling-edge pulse; the FSM, shadows and counters stay in the top module.
REQ-036 The block is placed between the player and the pixel generator inside the display driver, sharing iclock and ireset_n.

Verification
REQ-037 Tick: ivsync falls at cycle 100 -> oframe_tick is high in cycle 102 only; itemperatura = 5 appears on otemperatura in cycle 103.
REQ-038 Commit timing: iupd_req rises mid-frame with imusica = 16'h1234 -> omusica is unchanged until the next tick, then 16'h1234; oupd_ack rises the next cycle and falls after iupd_req drops.
REQ-039 Simultaneous: iupd_req rises in the same cycle as the tick -> commit on that tick with no frame delay; oupd_ack is high the following cycle.
REQ-040 Rotation with DWELL_FRAMES = 3 -> opage follows 0,0,0,1,1,1,2,2,2,0 over ticks. Committing a new imusica_atual during page 2 -> opage = 1 and the counter restarts.
REQ-041 Reset mid-operation: ireset_n pulses low in WAIT -> all outputs are 0 immediately, there is no commit on the next tick, and opage is 0.
REQ-042 Aborted request: iupd_req drops before the tick -> no commit, oupd_ack stays 0, and the state returns to RUN.

Source files
------------

// File: rtl/frame_update_controller_pkg.sv
// Shared encodings for the frame update controller: FSM states, display pages
// and the page rotation order.
package frame_update_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [1:0] PAGE_TEMP   = 2'd0;
    localparam logic [1:0] PAGE_SONG   = 2'd1;
    localparam logic [1:0] PAGE_AUTHOR = 2'd2;

    // Rotation order temp -> song -> author -> temp; any stray code returns to temp.
    function automatic logic [1:0] next_page(input logic [1:0] page);
        case (page)
            PAGE_TEMP: next_page = PAGE_SONG;
            PAGE_SONG: next_page = PAGE_AUTHOR;
            default:   next_page = PAGE_TEMP;
        endcase
    endfunction

endpackage

// File: rtl/frame_update_controller_vsync_edge_detect.sv
// Two-flop ivsync synchronizer with a registered one-cycle falling-edge pulse.
// The first sample after reset only seeds the history, so it never makes a tick.
module vsync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic sync_1;
    logic sync_2;
    logic primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            primed <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_1 <= vsync;
            sync_2 <= primed ? sync_1 : vsync;
            primed <= 1'b1;
            tick   <= primed & sync_2 & ~sync_1;
        end
    end

endmodule

// File: rtl/frame_update_controller.sv
// Frame-synchronous shadow registers, commit handshake and page/blink rotation
// between the music player and the pixel generator.
module frame_update_controller
    import frame_update_controller_pkg::*;
#(
    parameter int unsigned DWELL_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        iclock,
    input  logic        ireset_n,
    input  logic        ivsync,
    input  logic [3:0]  itemperatura,
    input  logic [3:0]  idig_temp,
    input  logic [15:0] iautor,
    input  logic [15:0] imusica,
    input  logic        imusica_atual,
    input  logic        iupd_req,
    output logic [3:0]  otemperatura,
    output logic [3:0]  odig_temp,
    output logic [15:0] oautor,
    output logic [15:0] omusica,
    output logic        omusica_atual,
    output logic        oupd_ack,
    output logic [1:0]  opage,
    output logic        oblink,
    output logic        oframe_tick
);

    localparam int unsigned DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    state_t          state;
    logic [DW-1:0]   frame_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            tick;
    logic            commit_c;
    logic            song_change_c;

    vsync_edge_detect u_vsync_edge_detect (
        .clk   (iclock),
        .rst_n (ireset_n),
        .vsync (ivsync),
        .tick  (tick)
    );

    assign oframe_tick = tick;

    // A pending or freshly raised request commits on the frame tick.
    always_comb begin
        commit_c      = 1'b0;
        song_change_c = 1'b0;
        if (tick && iupd_req && (state == ST_RUN || state == ST_WAIT)) begin
            commit_c = 1'b1;
        end
        song_change_c = commit_c && (imusica_atual != omusica_atual);
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state         <= ST_RUN;
            otemperatura  <= '0;
            odig_temp     <= '0;
            oautor        <= '0;
            omusica       <= '0;
            omusica_atual <= 1'b0;
            oupd_ack      <= 1'b0;
            opage         <= PAGE_TEMP;
            oblink        <= 1'b0;
            frame_cnt     <= '0;
            blink_cnt     <= '0;
        end else begin
            if (tick) begin
                otemperatura <= itemperatura;
                odig_temp    <= idig_temp;
            end

            if (commit_c) begin
                oautor        <= iautor;
                omusica       <= imusica;
                omusica_atual <= imusica_atual;
            end

            if (tick) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    oblink    <= ~oblink;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end

            // A new song jumps straight to the song page, overriding rotation.
            if (song_change_c) begin
                opage     <= PAGE_SONG;
                frame_cnt <= '0;
            end else if (tick) begin
                if (opage == 2'd3) begin
                    opage     <= PAGE_TEMP;
                    frame_cnt <= '0;
                end else if (frame_cnt == DW'(DWELL_FRAMES - 1)) begin
                    opage     <= next_page(opage);
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + DW'(1);
                end
            end

            case (state)
                ST_RUN: begin
                    if (iupd_req) begin
                        state    <= commit_c ? ST_ACK : ST_WAIT;
                        oupd_ack <= commit_c;
                    end
                end
                ST_WAIT: begin
                    if (!iupd_req) begin
                        state <= ST_RUN;
                    end else if (commit_c) begin
                        state    <= ST_ACK;
                        oupd_ack <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!iupd_req) begin
                        state    <= ST_RUN;
                        oupd_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    oupd_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_update_controller.sv
// Scoreboard bench: each frame pushes the expected post-tick output snapshot,
// a monitor pops and compares it in the cycle after every oframe_tick.
module tb_frame_update_controller;

    logic        iclock = 1'b0;
    logic        ireset_n;
    logic        ivsync;
    logic [3:0]  itemperatura;
    logic [3:0]  idig_temp;
    logic [15:0] iautor;
    logic [15:0] imusica;
    logic        imusica_atual;
    logic        iupd_req;
    logic [3:0]  otemperatura;
    logic [3:0]  odig_temp;
    logic [15:0] oautor;
    logic [15:0] omusica;
    logic        omusica_atual;
    logic        oupd_ack;
    logic [1:0]  opage;
    logic        oblink;
    logic        oframe_tick;

    typedef struct packed {
        logic [3:0]  temp;
        logic [3:0]  dig;
        logic [15:0] autor;
        logic [15:0] mus;
        logic        atual;
        logic [1:0]  page;
        logic        blink;
        logic        ack;
    } snap_t;

    snap_t exp_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    frame_no = 0;

    always #5 iclock = ~iclock;

    frame_update_controller #(
        .DWELL_FRAMES (3),
        .BLINK_FRAMES (2)
    ) dut (
        .iclock        (iclock),
        .ireset_n      (ireset_n),
        .ivsync        (ivsync),
        .itemperatura  (itemperatura),
        .idig_temp     (idig_temp),
        .iautor        (iautor),
        .imusica       (imusica),
        .imusica_atual (imusica_atual),
        .iupd_req      (iupd_req),
        .otemperatura  (otemperatura),
        .odig_temp     (odig_temp),
        .oautor        (oautor),
        .omusica       (omusica),
        .omusica_atual (omusica_atual),
        .oupd_ack      (oupd_ack),
        .opage         (opage),
        .oblink        (oblink),
        .oframe_tick   (oframe_tick)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic snap_t mk(input logic [3:0] t, input logic [3:0] d,
                                 input logic [15:0] a, input logic [15:0] m,
                                 input logic at, input logic [1:0] p,
                                 input logic b, input logic k);
        snap_t s;
        s.temp  = t;
        s.dig   = d;
        s.autor = a;
        s.mus   = m;
        s.atual = at;
        s.page  = p;
        s.blink = b;
        s.ack   = k;
        return s;
    endfunction

    // Monitor: the cycle after a tick, outputs must match the queued snapshot.
    initial begin
        snap_t e;
        snap_t act;
        forever begin
            @(negedge iclock);
            if (oframe_tick === 1'b1) begin
                @(negedge iclock);
                frame_no++;
                act = {otemperatura, odig_temp, oautor, omusica, omusica_atual,
                       opage, oblink, oupd_ack};
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_tick: tick %0d with no expected snapshot, outputs %0h",
                             frame_no, act);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame%0d_outputs", frame_no), 64'(act), 64'(e));
                end
            end
        end
    end

    // One frame: ivsync low for three cycles; tick expected exactly two cycles later.
    task automatic frame(input snap_t e, input bit req_at_tick);
        exp_q.push_back(e);
        itemperatura = e.temp;
        idig_temp    = e.dig;
        ivsync       = 1'b0;
        @(negedge iclock);
        check("tick_early", 64'(oframe_tick), 64'd0);
        @(negedge iclock);
        check("tick_on", 64'(oframe_tick), 64'd1);
        if (req_at_tick) iupd_req = 1'b1;
        @(negedge iclock);
        check("tick_off", 64'(oframe_tick), 64'd0);
        ivsync = 1'b1;
        repeat (6) @(negedge iclock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        ireset_n      = 1'b0;
        ivsync        = 1'b1;
        itemperatura  = 4'd0;
        idig_temp     = 4'd0;
        iautor        = 16'h0;
        imusica       = 16'h0;
        imusica_atual = 1'b0;
        iupd_req      = 1'b0;
        repeat (2) @(negedge iclock);
        check("reset_outputs", 64'({otemperatura, odig_temp, oautor, omusica, omusica_atual,
                                    oupd_ack, opage, oblink, oframe_tick}), 64'd0);
        ireset_n = 1'b1;
        repeat (4) @(negedge iclock);

        frame(mk(4'd5, 4'd1, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0), 1'b0);

        // Mid-frame request: song shadows hold until the tick.
        iautor        = 16'hABCD;
        imusica       = 16'h1234;
        imusica_atual = 1'b0;
        iupd_req      = 1'b1;
        repeat (3) @(negedge iclock);
        check("musica_held", 64'(omusica), 64'd0);
        check("ack_in_wait", 64'(oupd_ack), 64'd0);
        frame(mk(4'd7, 4'd2, 16'hABCD, 16'h1234, 1'b0, 2'd0, 1'b1, 1'b1), 1'b0);
        iupd_req = 1'b0;
        @(negedge iclock);
        check("ack_fall", 64'(oupd_ack), 64'd0);

        frame(mk(4'd3, 4'd3, 16'hABCD, 16'h1234, 1'b0, 2'd1, 1'b1, 1'b0), 1'b0);
        frame(mk(4'd4, 4'd4, 16'hABCD, 16'h1234, 1'b0, 2'd1, 1'b0, 1'b0), 1'b0);
        frame(mk(4'd5, 4'd5, 16'hABCD, 16'h1234, 1'b0, 2'd1, 1'b0, 1'b0), 1'b0);
        frame(mk(4'd6, 4'd6, 16'hABCD, 16'h1234, 1'b0, 2'd2, 1'b1, 1'b0), 1'b0);

        // Request raised in the tick cycle, new song index while on page 2.
        iautor        = 16'h0042;
        imusica       = 16'h5678;
        imusica_atual = 1'b1;
        frame(mk(4'd8, 4'd8, 16'h0042, 16'h5678, 1'b1, 2'd1, 1'b1, 1'b1), 1'b1);
        iupd_req = 1'b0;
        @(negedge iclock);
        check("ack_fall_2", 64'(oupd_ack), 64'd0);

        // Aborted request: withdrawn before the tick.
        iautor        = 16'h1111;
        imusica       = 16'h9999;
        imusica_atual = 1'b0;
        iupd_req      = 1'b1;
        repeat (3) @(negedge iclock);
        check("ack_abort_wait", 64'(oupd_ack), 64'd0);
        iupd_req = 1'b0;
        repeat (2) @(negedge iclock);
        frame(mk(4'd9, 4'd9, 16'h0042, 16'h5678, 1'b1, 2'd1, 1'b0, 1'b0), 1'b0);
        frame(mk(4'd10, 4'd10, 16'h0042, 16'h5678, 1'b1, 2'd1, 1'b0, 1'b0), 1'b0);
        frame(mk(4'd11, 4'd11, 16'h0042, 16'h5678, 1'b1, 2'd2, 1'b1, 1'b0), 1'b0);

        // Reset while waiting; ivsync held low across release must not tick.
        imusica_atual = 1'b1;
        iupd_req      = 1'b1;
        repeat (2) @(negedge iclock);
        ireset_n = 1'b0;
        #1;
        check("reset_midop_outputs", 64'({otemperatura, odig_temp, oautor, omusica, omusica_atual,
                                          oupd_ack, opage, oblink, oframe_tick}), 64'd0);
        ivsync   = 1'b0;
        iupd_req = 1'b0;
        repeat (2) @(negedge iclock);
        ireset_n = 1'b1;
        repeat (4) @(negedge iclock);
        ivsync = 1'b1;
        repeat (4) @(negedge iclock);
        frame(mk(4'd12, 4'd12, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0), 1'b0);

        repeat (4) @(negedge iclock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
